multi_field_action_unit: RTL and testbench

Pipelined, parametrised action unit that applies per-rule actions to NUM_FIELDS header fields in parallel. Each field has its own instruction memory indexed by the packet's PDR ID; each entry is a 4-bit opcode plus a DATA_WIDTH operand. It adds a valid/ready stream interface with backpressure, a per-field write port, and registered output. It sits between the PDR match stage and packet rewrite.

---
 rtl/multi_field_action_unit_pkg.sv | 39 +++
 rtl/multi_field_action_unit_if.sv | 29 ++
 rtl/multi_field_action_unit_field_lu.sv | 34 +++
 rtl/multi_field_action_unit.sv | 143 ++++++++++++++
 tb/tb_multi_field_action_unit.sv | 334 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_field_action_unit_pkg.sv
// Opcode encoding and instruction-word helpers shared by multi_field_action_unit.
// Instruction word layout: {opcode[OPCODE_W-1:0], operand[DATA_WIDTH-1:0]}.
package action_pkg;

  localparam int unsigned OPCODE_W         = 4;
  localparam int unsigned INSTR_DEF_DATA_W = 32;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP = 4'd0,
    OP_SET = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_CLR = 4'd7
  } opcode_e;

  // Packing helpers for the default 32-bit operand width.
  function automatic logic [OPCODE_W+INSTR_DEF_DATA_W-1:0] pack_instr(
    input logic [OPCODE_W-1:0]         op,
    input logic [INSTR_DEF_DATA_W-1:0] operand
  );
    return {op, operand};
  endfunction

  function automatic logic [OPCODE_W-1:0] instr_opcode(
    input logic [OPCODE_W+INSTR_DEF_DATA_W-1:0] w
  );
    return w[OPCODE_W+INSTR_DEF_DATA_W-1 -: OPCODE_W];
  endfunction

  function automatic logic [INSTR_DEF_DATA_W-1:0] instr_operand(
    input logic [OPCODE_W+INSTR_DEF_DATA_W-1:0] w
  );
    return w[INSTR_DEF_DATA_W-1:0];
  endfunction

endpackage

// File: rtl/multi_field_action_unit_if.sv
// Packet stream interface of multi_field_action_unit: input valid/ready side
// and registered output valid/ready side.
interface multi_field_action_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned NUM_FIELDS = 4
);

  logic                             in_valid;
  logic                             in_ready;
  logic [ADDR_WIDTH-1:0]            pdr_id;
  logic [NUM_FIELDS*DATA_WIDTH-1:0] header_in;
  logic [NUM_FIELDS-1:0]            bit_map_in;
  logic                             out_valid;
  logic                             out_ready;
  logic [NUM_FIELDS*DATA_WIDTH-1:0] header_out;
  logic [NUM_FIELDS-1:0]            bit_map_out;

  modport master (
    output in_valid, pdr_id, header_in, bit_map_in, out_ready,
    input  in_ready, out_valid, header_out, bit_map_out
  );

  modport slave (
    input  in_valid, pdr_id, header_in, bit_map_in, out_ready,
    output in_ready, out_valid, header_out, bit_map_out
  );

endinterface

// File: rtl/multi_field_action_unit_field_lu.sv
// field_lu: combinational action apply for one header field.
// Reserved opcodes (8..15) behave as NOP and do not flag the field as modified.
module field_lu
  import action_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic [DATA_WIDTH-1:0] h,
  input  logic [DATA_WIDTH-1:0] d,
  input  logic                  en,
  output logic [DATA_WIDTH-1:0] r,
  output logic                  mod
);

  always_comb begin
    r   = h;
    mod = 1'b0;
    if (en) begin
      mod = 1'b1;
      case (opcode)
        OP_SET:  r = d;
        OP_ADD:  r = h + d;
        OP_SUB:  r = h - d;
        OP_AND:  r = h & d;
        OP_OR:   r = h | d;
        OP_XOR:  r = h ^ d;
        OP_CLR:  r = '0;
        default: mod = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/multi_field_action_unit.sv
// Two-stage action unit: s1 latches header and per-field instruction, output stage
// registers the rewritten header. Optional hit counter under `ifdef ACTION_CNT_EN.
module multi_field_action_unit
  import action_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 2,
  parameter int unsigned NUM_FIELDS  = 4,
  localparam int unsigned FIELD_IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  multi_field_action_unit_if.slave     strm,
  input  logic                         we,
  input  logic [FIELD_IDX_W-1:0]       w_field,
  input  logic [ADDR_WIDTH-1:0]        w_addr,
  input  logic [DATA_WIDTH+OPCODE_W-1:0] wd
`ifdef ACTION_CNT_EN
  ,
  output logic [31:0]                  hit_count
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned IW    = DATA_WIDTH + OPCODE_W;
  localparam int unsigned HW    = NUM_FIELDS * DATA_WIDTH;

  typedef logic [IW-1:0] instr_t;

  instr_t                mem_q      [NUM_FIELDS][DEPTH];
  instr_t                mem_d      [NUM_FIELDS][DEPTH];
  instr_t                s1_instr_q [NUM_FIELDS];
  instr_t                s1_instr_d [NUM_FIELDS];
  logic                  s1_valid_q, s1_valid_d;
  logic [HW-1:0]         s1_hdr_q, s1_hdr_d;
  logic [NUM_FIELDS-1:0] s1_bm_q, s1_bm_d;
  logic                  out_valid_q, out_valid_d;
  logic [HW-1:0]         header_out_q, header_out_d;
  logic [NUM_FIELDS-1:0] bit_map_out_q, bit_map_out_d;
  logic [HW-1:0]         lu_hdr;
  logic [NUM_FIELDS-1:0] lu_bm;
  logic                  en;
  logic                  accept;

  assign en     = !out_valid_q || strm.out_ready;
  assign accept = strm.in_valid && en;

  assign strm.in_ready    = en;
  assign strm.out_valid   = out_valid_q;
  assign strm.header_out  = header_out_q;
  assign strm.bit_map_out = bit_map_out_q;

  // Writes land regardless of stall; a read on the same edge sees the old entry.
  always_comb begin
    mem_d = mem_q;
    if (we && (int'(w_field) < NUM_FIELDS)) begin
      mem_d[w_field][w_addr] = wd;
    end
  end

  for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_lu
    field_lu #(.DATA_WIDTH(DATA_WIDTH)) u_field_lu (
      .opcode (s1_instr_q[f][IW-1 -: OPCODE_W]),
      .h      (s1_hdr_q[f*DATA_WIDTH +: DATA_WIDTH]),
      .d      (s1_instr_q[f][DATA_WIDTH-1:0]),
      .en     (s1_bm_q[f]),
      .r      (lu_hdr[f*DATA_WIDTH +: DATA_WIDTH]),
      .mod    (lu_bm[f])
    );
  end

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_hdr_d      = s1_hdr_q;
    s1_bm_d       = s1_bm_q;
    s1_instr_d    = s1_instr_q;
    out_valid_d   = out_valid_q;
    header_out_d  = header_out_q;
    bit_map_out_d = bit_map_out_q;
    if (en) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_hdr_d = strm.header_in;
        s1_bm_d  = strm.bit_map_in;
        for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
          s1_instr_d[f] = mem_q[f][strm.pdr_id];
        end
      end
      out_valid_d   = s1_valid_q;
      header_out_d  = lu_hdr;
      bit_map_out_d = lu_bm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned f = 0; f < NUM_FIELDS; f++) begin
        for (int unsigned a = 0; a < DEPTH; a++) begin
          mem_q[f][a] <= '0;
        end
        s1_instr_q[f] <= '0;
      end
      s1_valid_q    <= 1'b0;
      s1_hdr_q      <= '0;
      s1_bm_q       <= '0;
      out_valid_q   <= 1'b0;
      header_out_q  <= '0;
      bit_map_out_q <= '0;
    end else begin
      mem_q         <= mem_d;
      s1_instr_q    <= s1_instr_d;
      s1_valid_q    <= s1_valid_d;
      s1_hdr_q      <= s1_hdr_d;
      s1_bm_q       <= s1_bm_d;
      out_valid_q   <= out_valid_d;
      header_out_q  <= header_out_d;
      bit_map_out_q <= bit_map_out_d;
    end
  end

`ifdef ACTION_CNT_EN
  logic [31:0] hit_count_q, hit_count_d;

  assign hit_count = hit_count_q;

  // Counts output handshakes that carried at least one modified field; saturating.
  always_comb begin
    hit_count_d = hit_count_q;
    if (out_valid_q && strm.out_ready && (|bit_map_out_q) && (hit_count_q != '1)) begin
      hit_count_d = hit_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q <= '0;
    end else begin
      hit_count_q <= hit_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_multi_field_action_unit.sv
// Scoreboard bench for multi_field_action_unit: a reference model predicts each
// accepted packet's result, the output monitor pops and compares in order.
`timescale 1ns/1ps
module tb_multi_field_action_unit;
  import action_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 2;
  localparam int unsigned NF = 4;
  localparam int unsigned HW = NF * DW;

  typedef struct packed {
    logic [HW-1:0] hdr;
    logic [NF-1:0] bm;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [1:0]    w_field;
  logic [AW-1:0] w_addr;
  logic [DW+3:0] wd;
`ifdef ACTION_CNT_EN
  logic [31:0]   hit_count;
`endif

  always #5 clk = ~clk;

  multi_field_action_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_FIELDS(NF)) bus ();

  multi_field_action_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_FIELDS(NF)) dut (
    .clk       (clk),
    .rst       (rst),
    .strm      (bus),
    .we        (we),
    .w_field   (w_field),
    .w_addr    (w_addr),
    .wd        (wd)
`ifdef ACTION_CNT_EN
    ,
    .hit_count (hit_count)
`endif
  );

  logic [DW+3:0] mdl_mem [NF][2**AW];
  exp_t          exp_q[$];
  logic [DW-1:0] seen_f0[$];
  int unsigned   n_tests = 0;
  int unsigned   n_fail  = 0;
  int unsigned   n_out   = 0;
  int unsigned   exp_hits = 0;
  logic [HW-1:0] last_hdr;
  logic [NF-1:0] last_bm;
  bit            done;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t predict(input logic [AW-1:0] id, input logic [HW-1:0] h,
                                   input logic [NF-1:0] bm);
    exp_t          e;
    logic [DW-1:0] x;
    logic [DW-1:0] d;
    logic [3:0]    op;
    e.hdr = h;
    e.bm  = '0;
    for (int f = 0; f < NF; f++) begin
      if (bm[f]) begin
        op = mdl_mem[f][id][DW+3:DW];
        d  = mdl_mem[f][id][DW-1:0];
        x  = h[f*DW +: DW];
        e.bm[f] = 1'b1;
        case (op)
          4'd1:    x = d;
          4'd2:    x = x + d;
          4'd3:    x = x - d;
          4'd4:    x = x & d;
          4'd5:    x = x | d;
          4'd6:    x = x ^ d;
          4'd7:    x = '0;
          default: e.bm[f] = 1'b0;
        endcase
        e.hdr[f*DW +: DW] = x;
      end
    end
    return e;
  endfunction

  // Reference model: predict at the accept edge using pre-write memory, then apply the write.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      exp_q.delete();
      for (int f = 0; f < NF; f++)
        for (int a = 0; a < 2**AW; a++) mdl_mem[f][a] = '0;
    end else begin
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(predict(bus.pdr_id, bus.header_in, bus.bit_map_in));
      if (we) mdl_mem[w_field][w_addr] = wd;
    end
  end

  // Output monitor: in-order compare on handshake, stability check while stalled.
  initial begin
    logic          hold_v;
    logic [HW-1:0] hold_hdr;
    logic [NF-1:0] hold_bm;
    exp_t          e;
    hold_v = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_hits = 0;
        hold_v   = 1'b0;
      end else begin
        if (hold_v) begin
          check("stall_valid", {127'd0, bus.out_valid}, 128'd1);
          check("stall_hdr", bus.header_out, hold_hdr);
          check("stall_bm", {124'd0, bus.bit_map_out}, {124'd0, hold_bm});
        end
        hold_v   = bus.out_valid && !bus.out_ready;
        hold_hdr = bus.header_out;
        hold_bm  = bus.bit_map_out;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 128'd1, 128'd0);
          end else begin
            e = exp_q.pop_front();
            check("hdr", bus.header_out, e.hdr);
            check("bm", {124'd0, bus.bit_map_out}, {124'd0, e.bm});
            if (|e.bm) exp_hits++;
          end
          last_hdr = bus.header_out;
          last_bm  = bus.bit_map_out;
          seen_f0.push_back(bus.header_out[DW-1:0]);
          n_out++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW-1:0] id, input logic [HW-1:0] h, input logic [NF-1:0] bm);
    bit          acc;
    int unsigned guard;
    bus.in_valid   = 1'b1;
    bus.pdr_id     = id;
    bus.header_in  = h;
    bus.bit_map_in = bm;
    guard = 0;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      tick();
      guard++;
    end while (!acc && guard < 50);
    if (!acc) check("send_timeout", 128'd0, 128'd1);
  endtask

  task automatic wr(input logic [1:0] f, input logic [AW-1:0] a, input logic [DW+3:0] w);
    we = 1'b1; w_field = f; w_addr = a; wd = w;
    tick();
    we = 1'b0;
  endtask

  task automatic drain();
    int unsigned guard = 0;
    bus.in_valid = 1'b0;
    while (exp_q.size() != 0 && guard < 100) begin
      tick();
      guard++;
    end
    check("drain_timeout", 128'(exp_q.size()), 128'd0);
    tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out_valid"}, {127'd0, bus.out_valid}, 128'd0);
    check({tag, "_in_ready"}, {127'd0, bus.in_ready}, 128'd1);
    check({tag, "_hdr"}, bus.header_out, 128'd0);
    check({tag, "_bm"}, {124'd0, bus.bit_map_out}, 128'd0);
`ifdef ACTION_CNT_EN
    check({tag, "_hits"}, {96'd0, hit_count}, 128'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [HW-1:0] h;
    int unsigned   base;
    rst = 1'b1; we = 1'b0; w_field = '0; w_addr = '0; wd = '0;
    bus.in_valid = 1'b0; bus.pdr_id = '0; bus.header_in = '0; bus.bit_map_in = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    check_idle("reset");
    rst = 1'b0;
    tick();

    // Empty memory acts as NOP; result visible after the edge following acceptance.
    send(2'd0, {4{32'h11}}, 4'hF);
    bus.in_valid = 1'b0;
    check("lat_k", {127'd0, bus.out_valid}, 128'd0);
    tick();
    check("lat_k1", {127'd0, bus.out_valid}, 128'd1);
    drain();
    check("nop_hdr", last_hdr, {4{32'h11}});
    check("nop_bm", {124'd0, last_bm}, 128'd0);

    // ADD/SUB wrap-around on fields 1 and 3.
    wr(2'd1, 2'd2, pack_instr(OP_ADD, 32'h5));
    wr(2'd3, 2'd2, pack_instr(OP_SUB, 32'h1));
    h = {32'h0, 32'h22, 32'hFFFF_FFFE, 32'h44};
    send(2'd2, h, 4'hF);
    drain();
    check("wrap_hdr", last_hdr, {32'hFFFF_FFFF, 32'h22, 32'h3, 32'h44});
    check("wrap_bm", {124'd0, last_bm}, 128'hA);
    send(2'd2, h, 4'b0010);
    drain();
    check("mask_hdr", last_hdr, {32'h0, 32'h22, 32'h3, 32'h44});
    check("mask_bm", {124'd0, last_bm}, 128'h2);

    // Back-to-back packets into a stalled output.
    base = n_out;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send(AW'(i), {$urandom, $urandom, $urandom, $urandom}, 4'(4'hF - i));
        bus.in_valid = 1'b0;
      end
      begin
        repeat (2) tick();
        @(negedge clk);
        check("stall_in_ready", {127'd0, bus.in_ready}, 128'd0);
        repeat (3) tick();
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("b2b_count", 128'(n_out - base), 128'd4);

    // Every opcode including reserved ones, with random output backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          wr(2'(i % 4), 2'd3, pack_instr(4'(i % 10), $urandom));
          send(2'd3, {$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)));
          send(2'd3, {$urandom, $urandom, $urandom, $urandom}, 4'hF);
          bus.in_valid = 1'b0;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          bus.out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    wr(2'd0, 2'd3, pack_instr(4'd9, 32'h1234));
    send(2'd3, {4{32'h5A}}, 4'h1);
    drain();
    check("reserved_f0", {96'd0, last_hdr[DW-1:0]}, 128'h5A);
    check("reserved_bm0", {127'd0, last_bm[0]}, 128'd0);

    // Write and read of the same entry on one edge: old action first, new action next.
    wr(2'd0, 2'd1, pack_instr(OP_XOR, 32'hF0));
    seen_f0.delete();
    bus.in_valid = 1'b1; bus.pdr_id = 2'd1; bus.header_in = {4{32'h0F}}; bus.bit_map_in = 4'h1;
    we = 1'b1; w_field = 2'd0; w_addr = 2'd1; wd = pack_instr(OP_SET, 32'hAA);
    @(negedge clk);
    check("same_edge_rdy", {127'd0, bus.in_ready}, 128'd1);
    tick();
    we = 1'b0;
    tick();
    drain();
    check("same_edge_cnt", 128'(seen_f0.size()), 128'd2);
    if (seen_f0.size() == 2) begin
      check("same_edge_old", {96'd0, seen_f0[0]}, 128'hFF);
      check("same_edge_new", {96'd0, seen_f0[1]}, 128'hAA);
    end

    // Hit counting from a clean state, then reset with packets in flight.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    wr(2'd0, 2'd0, pack_instr(OP_SET, 32'h1));
    for (int i = 0; i < 5; i++) send(2'd0, {4{32'h77}}, 4'(1 - (i % 2)));
    drain();
`ifdef ACTION_CNT_EN
    check("hits_model", 128'(exp_hits), 128'd3);
    check("hits_dut", {96'd0, hit_count}, 128'd3);
`endif
    bus.out_ready = 1'b0;
    send(2'd0, {4{32'h99}}, 4'h1);
    send(2'd0, {4{32'h98}}, 4'h1);
    bus.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_idle("midrst");
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check_idle("postrst");
    check("postrst_q", 128'(exp_q.size()), 128'd0);
    send(2'd0, {4{32'h66}}, 4'h1);
    drain();
    check("postrst_mem_hdr", last_hdr, {4{32'h66}});
    check("postrst_mem_bm", {124'd0, last_bm}, 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
